// File: rtl/priority_bit_scanner_pkg.sv
// Shared types and bit-manipulation helpers for the priority bit scanner.
// The helpers work on a 64-bit container, which is the widest legal word.
// Callers zero-extend narrower vectors and truncate the result back.
package priority_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned MAX_IDX_W = 6;

  // Two's-complement trick: x & -x leaves only the lowest set bit.
  function automatic logic [MAX_WIDTH-1:0] isolate_lsb(input logic [MAX_WIDTH-1:0] x);
    return x & (~x + 64'd1);
  endfunction

  // Highest set bit; an ascending scan lets the last hit win.
  function automatic logic [MAX_WIDTH-1:0] isolate_msb(input logic [MAX_WIDTH-1:0] x);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (x[i]) r = 64'd1 << i;
    end
    return r;
  endfunction

  // OR-reduction encoder; exact for a one-hot input, 0 for an all-zero input.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_WIDTH-1:0] oh);
    logic [MAX_IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (oh[i]) r = r | 6'(i);
    end
    return r;
  endfunction

  // True when at most one bit is set (clearing the lowest set bit leaves zero).
  function automatic logic at_most_one(input logic [MAX_WIDTH-1:0] x);
    return (x & (x - 64'd1)) == 64'd0;
  endfunction

endpackage

// File: rtl/priority_bit_scanner_pick.sv
// Combinational picker: selects the next bit of the residual word in the
// requested direction, encodes its index and flags the final bit.
module priority_pick #(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             dir,
  output logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             single
);
  import priority_pkg::*;

  // dir=0 picks the lowest set bit, dir=1 the highest; single flags popcount<=1.
  always_comb begin
    onehot = dir ? WIDTH'(isolate_msb(64'(vec))) : WIDTH'(isolate_lsb(64'(vec)));
    idx    = IDX_W'(onehot_to_idx(64'(onehot)));
    single = at_most_one(64'(vec));
  end

endmodule

// File: rtl/priority_bit_scanner.sv
// Streaming priority bit scanner: accepts a word per handshake and emits each
// set bit as its own beat, LSB-first or MSB-first as chosen with the word.
//
//  state | meaning
//  IDLE  | no word held; data_ready_o=1, waiting for data_val_i
//  SCAN  | residual holds the bits still to emit; val_o=1 every cycle
//
// Every output except data_ready_o is decoded from registered state only, so
// data_i never reaches the outputs combinationally. data_ready_o also rises on
// the last-beat transfer so the following word loads without a bubble cycle.
module priority_bit_scanner #(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             zero_o,
  output logic             last_o,
  output logic             val_o,
  input  logic             ready_i
);
  import priority_pkg::*;

  scan_state_t      state_q, state_d;
  logic [WIDTH-1:0] residual_q, residual_d;
  logic             dir_q, dir_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_single;

  priority_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .vec    (residual_q),
    .dir    (dir_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .single (pick_single)
  );

  // State and word registers; reset clears everything so val_o drops at once.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      residual_q <= '0;
      dir_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      dir_q      <= dir_d;
      zero_q     <= zero_d;
    end
  end

  // Next-state, residual update and output decode.
  always_comb begin
    state_d      = state_q;
    residual_d   = residual_q;
    dir_d        = dir_q;
    zero_d       = zero_q;
    val_o        = 1'b0;
    onehot_o     = '0;
    idx_o        = '0;
    zero_o       = 1'b0;
    last_o       = 1'b0;
    data_ready_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        data_ready_o = 1'b1;
      end
      SCAN: begin
        val_o    = 1'b1;
        onehot_o = pick_onehot;
        idx_o    = pick_idx;
        zero_o   = zero_q;
        last_o   = pick_single;
        if (ready_i) begin
          if (pick_single) begin
            // Final beat leaves; a word accepted below overrides the IDLE return.
            data_ready_o = 1'b1;
            state_d      = IDLE;
          end else begin
            residual_d = residual_q & ~pick_onehot;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new word is only sampled here, so later changes on data_i/dir_i are ignored.
    if (data_val_i && data_ready_o) begin
      state_d    = SCAN;
      residual_d = data_i;
      dir_d      = dir_i;
      zero_d     = (data_i == '0);
    end
  end

endmodule

// File: tb/tb_priority_bit_scanner.sv
// Scoreboard bench for priority_bit_scanner at WIDTH=5: the driver pushes the
// expected beat list for each accepted word, the monitor pops on each transfer.
module tb_priority_bit_scanner;

  localparam int WIDTH = 5;
  localparam int IDX_W = 3;

  logic             clk_i = 1'b0;
  logic             arst_i = 1'b1;
  logic [WIDTH-1:0] data_i = '0;
  logic             dir_i = 1'b0;
  logic             data_val_i = 1'b0;
  logic             data_ready_o;
  logic [WIDTH-1:0] onehot_o;
  logic [IDX_W-1:0] idx_o;
  logic             zero_o;
  logic             last_o;
  logic             val_o;
  logic             ready_i = 1'b0;

  priority_bit_scanner #(
    .WIDTH (WIDTH)
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .data_i       (data_i),
    .dir_i        (dir_i),
    .data_val_i   (data_val_i),
    .data_ready_o (data_ready_o),
    .onehot_o     (onehot_o),
    .idx_o        (idx_o),
    .zero_o       (zero_o),
    .last_o       (last_o),
    .val_o        (val_o),
    .ready_i      (ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [WIDTH-1:0] onehot;
    logic [IDX_W-1:0] idx;
    logic             zero;
    logic             last;
  } beat_t;

  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic             dir;
  } word_t;

  beat_t exp_q[$];
  word_t stim_q[$];
  bit    rdy_pat[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int last_xfer_cyc = 0;
  bit rdy_random = 1'b0;
  bit gap_random = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: list the set-bit positions, walk them in the chosen order.
  function automatic void push_expected(input logic [WIDTH-1:0] w, input logic d);
    int    pos[$];
    beat_t b;
    for (int i = 0; i < WIDTH; i++) if (w[i]) pos.push_back(i);
    if (pos.size() == 0) begin
      b.onehot = '0;
      b.idx    = '0;
      b.zero   = 1'b1;
      b.last   = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int k = 0; k < pos.size(); k++) begin
        int bit_pos;
        bit_pos  = d ? pos[pos.size() - 1 - k] : pos[k];
        b.onehot = WIDTH'(1) << bit_pos;
        b.idx    = IDX_W'(bit_pos);
        b.zero   = 1'b0;
        b.last   = (k == pos.size() - 1);
        exp_q.push_back(b);
      end
    end
  endfunction

  // Monitor: compares each transferred beat and checks outputs hold during stalls.
  beat_t prev_b;
  logic  prev_stall = 1'b0;
  always @(negedge clk_i) begin
    beat_t cur, e;
    #2;
    cur.onehot = onehot_o;
    cur.idx    = idx_o;
    cur.zero   = zero_o;
    cur.last   = last_o;
    if (arst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_val_held", 32'(val_o), 32'd1);
        check("stall_beat_held", 32'(cur), 32'(prev_b));
      end
      if (val_o && !ready_i) check("stall_data_ready", 32'(data_ready_o), 32'd0);
      if (val_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("beat_onehot", 32'(onehot_o), 32'(e.onehot));
          check("beat_idx", 32'(idx_o), 32'(e.idx));
          check("beat_zero", 32'(zero_o), 32'(e.zero));
          check("beat_last", 32'(last_o), 32'(e.last));
        end
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
      prev_stall = val_o && !ready_i;
      prev_b     = cur;
    end
  end

  // One driven cycle: inputs set on the falling edge, acceptance judged 1 unit later.
  int first_acc;
  task automatic drive_cycle();
    @(negedge clk_i);
    if (rdy_pat.size() != 0) ready_i = rdy_pat.pop_front();
    else if (rdy_random)     ready_i = ($urandom_range(0, 3) != 0);
    else                     ready_i = 1'b1;
    if (stim_q.size() != 0 && !(gap_random && $urandom_range(0, 3) == 0)) begin
      data_val_i = 1'b1;
      data_i     = stim_q[0].word;
      dir_i      = stim_q[0].dir;
    end else begin
      data_val_i = 1'b0;
      data_i     = WIDTH'($urandom);
      dir_i      = 1'($urandom);
    end
    #1;
    if (data_val_i && data_ready_o) begin
      push_expected(data_i, dir_i);
      void'(stim_q.pop_front());
      if (first_acc < 0) first_acc = cyc;
    end
  endtask

  // Drain all queued words; span = cycles from first acceptance to final transfer.
  task automatic run(input string name, input int exp_span);
    int budget;
    budget    = 0;
    first_acc = -1;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && budget < 4000) begin
      drive_cycle();
      budget++;
    end
    check({name, "_pending"}, 32'(stim_q.size() + exp_q.size()), 32'd0);
    if (exp_span >= 0) check({name, "_span"}, 32'(last_xfer_cyc - first_acc), 32'(exp_span));
    exp_q.delete();
    stim_q.delete();
  endtask

  function automatic void add_word(input logic [WIDTH-1:0] w, input logic d);
    word_t s;
    s.word = w;
    s.dir  = d;
    stim_q.push_back(s);
  endfunction

  initial begin
    int base, b, r;
    logic [WIDTH-1:0] w;

    // Reset state, including while inputs wiggle.
    data_val_i = 1'b1;
    data_i     = 5'b10110;
    repeat (2) @(negedge clk_i);
    check("rst_val", 32'(val_o), 32'd0);
    check("rst_onehot", 32'(onehot_o), 32'd0);
    check("rst_idx", 32'(idx_o), 32'd0);
    check("rst_zero", 32'(zero_o), 32'd0);
    check("rst_last", 32'(last_o), 32'd0);
    data_val_i = 1'b0;
    arst_i     = 1'b0;
    @(negedge clk_i);
    check("idle_ready", 32'(data_ready_o), 32'd1);
    check("idle_val", 32'(val_o), 32'd0);

    // Directed cases.
    add_word(5'b10110, 1'b0);
    run("lsb_first", 3);
    add_word(5'b10110, 1'b1);
    run("msb_first", 3);
    add_word(5'b00000, 1'b0);
    add_word(5'b00100, 1'b0);
    run("zero_then_next", 2);
    add_word(5'b11111, 1'b0);
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run("backpressure", 7);
    add_word(5'b00101, 1'b0);
    add_word(5'b01000, 1'b0);
    run("back_to_back", 3);

    // Reset in the middle of a scan.
    add_word(5'b11111, 1'b1);
    first_acc = -1;
    base      = xfer_cnt;
    b         = 0;
    while (xfer_cnt < base + 2 && b < 50) begin
      drive_cycle();
      b++;
    end
    check("pre_reset_beats", 32'(xfer_cnt - base), 32'd2);
    check("pre_reset_val", 32'(val_o), 32'd1);
    arst_i = 1'b1;
    #1;
    check("reset_val_drop", 32'(val_o), 32'd0);
    check("reset_onehot", 32'(onehot_o), 32'd0);
    check("reset_last", 32'(last_o), 32'd0);
    exp_q.delete();
    stim_q.delete();
    @(negedge clk_i);
    arst_i = 1'b0;
    @(negedge clk_i);
    check("post_reset_ready", 32'(data_ready_o), 32'd1);
    add_word(5'b00001, 1'b0);
    run("after_reset", 1);

    // Randomized words, gaps and backpressure.
    rdy_random = 1'b1;
    gap_random = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      w = '0;
      else if (r == 1) w = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
      else if (r == 2) w = '1;
      else             w = WIDTH'($urandom);
      add_word(w, 1'($urandom));
    end
    run("random", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
